// File: rtl/manage_msg_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : manage_msg_dispatch
// Brief    : Routes VR manage messages: COMMIT type goes to the commit engine
//            (first line + udp_info). All other types pass to the dst stream.
// Revision : 1.0
// ============================================================================
module manage_msg_dispatch #(
  parameter int                    NOC_DATA_W  = 512,
  parameter int                    MSG_TYPE_W  = 8,
  parameter int                    UDP_INFO_W  = 96,
  parameter logic [MSG_TYPE_W-1:0] COMMIT_TYPE = MSG_TYPE_W'(4)
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  src_manage_rx_hdr_val,
  input  logic [UDP_INFO_W-1:0] src_manage_rx_hdr,
  output logic                  manage_src_rx_hdr_rdy,

  input  logic                  src_manage_rx_data_val,
  input  logic [NOC_DATA_W-1:0] src_manage_rx_data,
  input  logic                  src_manage_rx_data_last,
  output logic                  manage_src_rx_data_rdy,

  output logic                  manage_commit_req_val,
  output logic [NOC_DATA_W-1:0] manage_commit_req,
  output logic [UDP_INFO_W-1:0] manage_commit_pkt_info,
  input  logic                  commit_manage_req_rdy,

  output logic                  manage_dst_hdr_val,
  output logic [UDP_INFO_W-1:0] manage_dst_hdr,
  input  logic                  manage_dst_hdr_rdy,

  output logic                  manage_dst_data_val,
  output logic [NOC_DATA_W-1:0] manage_dst_data,
  output logic                  manage_dst_data_last,
  input  logic                  manage_dst_data_rdy,

  output logic [31:0]           manage_commit_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FIRST     = 3'd1,
    ST_COMMIT    = 3'd2,
    ST_DRAIN     = 3'd3,
    ST_OUT_HDR   = 3'd4,
    ST_OUT_FIRST = 3'd5,
    ST_OUT_PASS  = 3'd6
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [UDP_INFO_W-1:0] r_info;
  logic [NOC_DATA_W-1:0] r_line;
  logic                  r_last;
  logic [31:0]           r_commit_cnt;

  logic                  w_hdr_xfer;
  logic                  w_first_xfer;
  logic                  w_commit_xfer;
  logic                  w_is_commit;

  assign w_is_commit   = (src_manage_rx_data[NOC_DATA_W-1 -: MSG_TYPE_W] == COMMIT_TYPE);
  assign w_hdr_xfer    = src_manage_rx_hdr_val & manage_src_rx_hdr_rdy;
  assign w_first_xfer  = (r_state == ST_FIRST) & src_manage_rx_data_val & manage_src_rx_data_rdy;
  assign w_commit_xfer = manage_commit_req_val & commit_manage_req_rdy;

  assign manage_commit_req      = r_line;
  assign manage_commit_pkt_info = r_info;
  assign manage_dst_hdr         = r_info;
  assign manage_commit_cnt      = r_commit_cnt;
  // Only OUT_PASS cuts through; every other state presents the captured line 0.
  assign manage_dst_data        = (r_state == ST_OUT_PASS) ? src_manage_rx_data : r_line;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state           = r_state;
    manage_src_rx_hdr_rdy  = 1'b0;
    manage_src_rx_data_rdy = 1'b0;
    manage_commit_req_val  = 1'b0;
    manage_dst_hdr_val     = 1'b0;
    manage_dst_data_val    = 1'b0;
    manage_dst_data_last   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        manage_src_rx_hdr_rdy = 1'b1;
        if (src_manage_rx_hdr_val) w_next_state = ST_FIRST;
      end
      ST_FIRST: begin
        manage_src_rx_data_rdy = 1'b1;
        if (src_manage_rx_data_val) w_next_state = w_is_commit ? ST_COMMIT : ST_OUT_HDR;
      end
      ST_COMMIT: begin
        manage_commit_req_val = 1'b1;
        if (commit_manage_req_rdy) w_next_state = r_last ? ST_IDLE : ST_DRAIN;
      end
      ST_DRAIN: begin
        manage_src_rx_data_rdy = 1'b1;
        if (src_manage_rx_data_val && src_manage_rx_data_last) w_next_state = ST_IDLE;
      end
      ST_OUT_HDR: begin
        manage_dst_hdr_val = 1'b1;
        if (manage_dst_hdr_rdy) w_next_state = ST_OUT_FIRST;
      end
      ST_OUT_FIRST: begin
        manage_dst_data_val  = 1'b1;
        manage_dst_data_last = r_last;
        if (manage_dst_data_rdy) w_next_state = r_last ? ST_IDLE : ST_OUT_PASS;
      end
      ST_OUT_PASS: begin
        manage_dst_data_val    = src_manage_rx_data_val;
        manage_dst_data_last   = src_manage_rx_data_last;
        manage_src_rx_data_rdy = manage_dst_data_rdy;
        if (src_manage_rx_data_val && manage_dst_data_rdy && src_manage_rx_data_last)
          w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
    // Handshakes are silenced during reset so a half-finished message cannot leak out.
    if (rst) begin
      w_next_state           = ST_IDLE;
      manage_src_rx_hdr_rdy  = 1'b0;
      manage_src_rx_data_rdy = 1'b0;
      manage_commit_req_val  = 1'b0;
      manage_dst_hdr_val     = 1'b0;
      manage_dst_data_val    = 1'b0;
      manage_dst_data_last   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_info       <= '0;
      r_line       <= '0;
      r_last       <= 1'b0;
      r_commit_cnt <= '0;
    end else begin
      if (w_hdr_xfer) r_info <= src_manage_rx_hdr;
      if (w_first_xfer) begin
        r_line <= src_manage_rx_data;
        r_last <= src_manage_rx_data_last;
      end
      if (w_commit_xfer) r_commit_cnt <= r_commit_cnt + 32'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_manage_msg_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : tb_manage_msg_dispatch
// Brief    : Directed self-checking bench for manage_msg_dispatch.
// Revision : 1.0
// ============================================================================
module tb_manage_msg_dispatch;
  localparam int c_DW = 64;
  localparam int c_IW = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            hdr_val = 1'b0;
  logic [c_IW-1:0] hdr = '0;
  logic            hdr_rdy;
  logic            data_val = 1'b0;
  logic [c_DW-1:0] data = '0;
  logic            data_last = 1'b0;
  logic            data_rdy;
  logic            commit_val;
  logic [c_DW-1:0] commit_req;
  logic [c_IW-1:0] commit_info;
  logic            commit_rdy = 1'b1;
  logic            dst_hdr_val;
  logic [c_IW-1:0] dst_hdr;
  logic            dst_hdr_rdy = 1'b1;
  logic            dst_data_val;
  logic [c_DW-1:0] dst_data;
  logic            dst_data_last;
  logic            dst_data_rdy = 1'b1;
  logic [31:0]     cnt;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  logic tog_en = 1'b0;

  logic [c_DW-1:0] q_commit[$];
  logic [c_IW-1:0] q_commit_info[$];
  int              q_commit_cyc[$];
  logic [c_IW-1:0] q_dhdr[$];
  logic [c_DW-1:0] q_ddata[$];
  logic            q_dlast[$];

  manage_msg_dispatch #(
    .NOC_DATA_W (c_DW),
    .MSG_TYPE_W (8),
    .UDP_INFO_W (c_IW),
    .COMMIT_TYPE(8'd4)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .src_manage_rx_hdr_val  (hdr_val),
    .src_manage_rx_hdr      (hdr),
    .manage_src_rx_hdr_rdy  (hdr_rdy),
    .src_manage_rx_data_val (data_val),
    .src_manage_rx_data     (data),
    .src_manage_rx_data_last(data_last),
    .manage_src_rx_data_rdy (data_rdy),
    .manage_commit_req_val  (commit_val),
    .manage_commit_req      (commit_req),
    .manage_commit_pkt_info (commit_info),
    .commit_manage_req_rdy  (commit_rdy),
    .manage_dst_hdr_val     (dst_hdr_val),
    .manage_dst_hdr         (dst_hdr),
    .manage_dst_hdr_rdy     (dst_hdr_rdy),
    .manage_dst_data_val    (dst_data_val),
    .manage_dst_data        (dst_data),
    .manage_dst_data_last   (dst_data_last),
    .manage_dst_data_rdy    (dst_data_rdy),
    .manage_commit_cnt      (cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    #1;
    dst_data_rdy = tog_en ? ~dst_data_rdy : 1'b1;
  end

  // Transfers observed mid-cycle; inputs only move just after the rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (commit_val && commit_rdy) begin
        q_commit.push_back(commit_req);
        q_commit_info.push_back(commit_info);
        q_commit_cyc.push_back(cyc);
      end
      if (dst_hdr_val && dst_hdr_rdy) q_dhdr.push_back(dst_hdr);
      if (dst_data_val && dst_data_rdy) begin
        q_ddata.push_back(dst_data);
        q_dlast.push_back(dst_data_last);
      end
    end
  end

  task automatic clear_q();
    q_commit.delete(); q_commit_info.delete(); q_commit_cyc.delete();
    q_dhdr.delete(); q_ddata.delete(); q_dlast.delete();
  endtask

  // Called just after a rising edge; returns just after the transferring edge.
  task automatic push_hdr(input logic [c_IW-1:0] info);
    int n = 0;
    hdr_val = 1'b1; hdr = info;
    @(negedge clk);
    while (!hdr_rdy && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin total_cnt++; $display("FAIL hdr_timeout: got no hdr_rdy, required hdr_rdy=1"); end
    @(posedge clk); #1;
    hdr_val = 1'b0;
  endtask

  task automatic push_line(input logic [c_DW-1:0] d, input logic l);
    int n = 0;
    data_val = 1'b1; data = d; data_last = l;
    @(negedge clk);
    while (!data_rdy && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin total_cnt++; $display("FAIL data_timeout: got no data_rdy, required data_rdy=1"); end
    @(posedge clk); #1;
    data_val = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if ({hdr_rdy, data_rdy, commit_val, dst_hdr_val, dst_data_val} !== 5'b0)
      $display("FAIL reset_vals: got %b required 00000", {hdr_rdy, data_rdy, commit_val, dst_hdr_val, dst_data_val});
    else pass_cnt++;
    total_cnt++;
    if (cnt !== 32'd0) $display("FAIL reset_cnt: got %0d required 0", cnt); else pass_cnt++;
    @(posedge clk); #1; rst = 1'b0;
    data_val = 1'b1; data = 64'h0400_0000_0000_0001; data_last = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (hdr_rdy !== 1'b1) $display("FAIL idle_hdr_rdy: got %b required 1", hdr_rdy); else pass_cnt++;
    total_cnt++;
    if (data_rdy !== 1'b0) $display("FAIL idle_data_rdy: got %b required 0", data_rdy); else pass_cnt++;
    @(posedge clk); #1; data_val = 1'b0;
  endtask

  task automatic test_single_commit();
    clear_q();
    hdr_val = 1'b1; hdr = 32'hA1A1_0001;
    @(negedge clk);
    total_cnt++;
    if (hdr_rdy !== 1'b1) $display("FAIL t1_hdr_rdy: got %b required 1", hdr_rdy); else pass_cnt++;
    @(posedge clk); #1;
    hdr_val = 1'b0; data_val = 1'b1; data = 64'h04DE_ADBE_EF01_2345; data_last = 1'b1;
    @(negedge clk);
    total_cnt++;
    if ({data_rdy, commit_val} !== 2'b10) $display("FAIL t1_first: got rdy/val %b required 10", {data_rdy, commit_val}); else pass_cnt++;
    @(posedge clk); #1; data_val = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (commit_val !== 1'b1) $display("FAIL t1_commit_val: got %b required 1", commit_val); else pass_cnt++;
    total_cnt++;
    if (commit_req !== 64'h04DE_ADBE_EF01_2345) $display("FAIL t1_commit_req: got %h required 04deadbeef012345", commit_req); else pass_cnt++;
    total_cnt++;
    if (commit_info !== 32'hA1A1_0001) $display("FAIL t1_commit_info: got %h required a1a10001", commit_info); else pass_cnt++;
    total_cnt++;
    if (cnt !== 32'd0) $display("FAIL t1_cnt_before: got %0d required 0", cnt); else pass_cnt++;
    @(posedge clk); #1;
    @(negedge clk);
    total_cnt++;
    if ({commit_val, hdr_rdy} !== 2'b01) $display("FAIL t1_idle: got val/hdr_rdy %b required 01", {commit_val, hdr_rdy}); else pass_cnt++;
    total_cnt++;
    if (cnt !== 32'd1) $display("FAIL t1_cnt_after: got %0d required 1", cnt); else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_commit_drain();
    clear_q();
    push_hdr(32'hC0DE_0002);
    push_line(64'h0411_1111_1111_1111, 1'b0);
    push_line(64'h0122_2222_2222_2222, 1'b0);
    push_line(64'h0433_3333_3333_3333, 1'b1);
    repeat (3) @(posedge clk); #1;
    @(negedge clk);
    total_cnt++;
    if (q_commit.size() != 1) $display("FAIL t2_req_count: got %0d required 1", q_commit.size()); else pass_cnt++;
    total_cnt++;
    if ((q_commit.size() > 0 ? q_commit[0] : 64'hx) !== 64'h0411_1111_1111_1111)
      $display("FAIL t2_req_line: got %h required 0411111111111111", q_commit.size() > 0 ? q_commit[0] : 64'hx);
    else pass_cnt++;
    total_cnt++;
    if (q_dhdr.size() + q_ddata.size() != 0) $display("FAIL t2_dst_activity: got %0d transfers required 0", q_dhdr.size() + q_ddata.size()); else pass_cnt++;
    total_cnt++;
    if ({cnt, hdr_rdy} !== {32'd2, 1'b1}) $display("FAIL t2_cnt_idle: got cnt %0d hdr_rdy %b required cnt 2 hdr_rdy 1", cnt, hdr_rdy); else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_passthrough();
    logic [c_DW-1:0] lines [4];
    lines[0] = 64'h0100_0000_AAAA_0000;
    lines[1] = 64'h0400_0000_AAAA_0001;
    lines[2] = 64'hFF00_0000_AAAA_0002;
    lines[3] = 64'h0000_0000_AAAA_0003;
    clear_q();
    tog_en = 1'b1;
    push_hdr(32'h1111_0003);
    for (int i = 0; i < 4; i++) push_line(lines[i], i == 3);
    repeat (4) @(posedge clk);
    tog_en = 1'b0;
    repeat (2) @(posedge clk); #1;
    total_cnt++;
    if (q_dhdr.size() != 1 || q_dhdr[0] !== 32'h1111_0003)
      $display("FAIL t3_dst_hdr: got %0d hdrs first %h required 1 hdr 11110003", q_dhdr.size(), q_dhdr.size() > 0 ? q_dhdr[0] : 32'hx);
    else pass_cnt++;
    total_cnt++;
    if (q_ddata.size() != 4) $display("FAIL t3_line_count: got %0d required 4", q_ddata.size()); else pass_cnt++;
    for (int i = 0; i < 4 && i < q_ddata.size(); i++) begin
      total_cnt++;
      if (q_ddata[i] !== lines[i] || q_dlast[i] !== (i == 3))
        $display("FAIL t3_line%0d: got %h last %b required %h last %b", i, q_ddata[i], q_dlast[i], lines[i], i == 3);
      else pass_cnt++;
    end
    total_cnt++;
    if (q_commit.size() != 0 || cnt !== 32'd2) $display("FAIL t3_no_commit: got %0d reqs cnt %0d required 0 reqs cnt 2", q_commit.size(), cnt); else pass_cnt++;
  endtask

  task automatic test_commit_stall();
    logic stable = 1'b1;
    clear_q();
    commit_rdy = 1'b0;
    push_hdr(32'h5757_0004);
    push_line(64'h04CA_FE00_0000_0044, 1'b1);
    data_val = 1'b1; data = 64'h0400_0000_0000_0099; data_last = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (commit_val !== 1'b1 || commit_req !== 64'h04CA_FE00_0000_0044 ||
          commit_info !== 32'h5757_0004 || data_rdy !== 1'b0 || cnt !== 32'd2)
        stable = 1'b0;
    end
    total_cnt++;
    if (stable !== 1'b1) $display("FAIL t4_stall_hold: got stable=%b required 1", stable); else pass_cnt++;
    commit_rdy = 1'b1;
    @(posedge clk); #1; data_val = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({cnt, commit_val} !== {32'd3, 1'b0}) $display("FAIL t4_release: got cnt %0d val %b required cnt 3 val 0", cnt, commit_val); else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_msg();
    clear_q();
    push_hdr(32'hDEAD_0005);
    push_line(64'h0455_0000_0000_0000, 1'b0);
    push_line(64'h0455_0000_0000_0001, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    total_cnt++;
    if ({hdr_rdy, data_rdy, commit_val, dst_hdr_val, dst_data_val} !== 5'b0)
      $display("FAIL t5_rst_vals: got %b required 00000", {hdr_rdy, data_rdy, commit_val, dst_hdr_val, dst_data_val});
    else pass_cnt++;
    @(posedge clk); #1;
    @(negedge clk);
    total_cnt++;
    if (cnt !== 32'd0) $display("FAIL t5_rst_cnt: got %0d required 0", cnt); else pass_cnt++;
    @(posedge clk); #1; rst = 1'b0;
    clear_q();
    push_hdr(32'hBEEF_0006);
    push_line(64'h0466_6666_0000_0000, 1'b1);
    repeat (2) @(posedge clk); #1;
    total_cnt++;
    if (q_commit.size() != 1 || q_commit[0] !== 64'h0466_6666_0000_0000 || q_commit_info[0] !== 32'hBEEF_0006)
      $display("FAIL t5_after_rst: got %0d reqs line %h required 1 req 0466666600000000 info beef0006",
               q_commit.size(), q_commit.size() > 0 ? q_commit[0] : 64'hx);
    else pass_cnt++;
    total_cnt++;
    if (cnt !== 32'd1) $display("FAIL t5_cnt: got %0d required 1", cnt); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    clear_q();
    fork
      for (int i = 0; i < 20; i++) push_hdr(32'hB000_0000 + i);
      for (int i = 0; i < 20; i++) push_line({8'h04, 24'h0, 32'(i)}, 1'b1);
    join
    repeat (3) @(posedge clk); #1;
    total_cnt++;
    if (q_commit.size() != 20) $display("FAIL t6_req_count: got %0d required 20", q_commit.size()); else pass_cnt++;
    for (int i = 0; i < q_commit.size(); i++) begin
      if (q_commit[i] !== {8'h04, 24'h0, 32'(i)} || q_commit_info[i] !== 32'hB000_0000 + i) bad++;
      if (i > 0 && q_commit_cyc[i] - q_commit_cyc[i-1] != 3) bad++;
    end
    total_cnt++;
    if (bad != 0) $display("FAIL t6_order_spacing: got %0d bad entries required 0", bad); else pass_cnt++;
    total_cnt++;
    if (cnt !== 32'd20) $display("FAIL t6_cnt: got %0d required 20", cnt); else pass_cnt++;

    force dut.r_commit_cnt = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    release dut.r_commit_cnt;
    @(negedge clk);
    total_cnt++;
    if (cnt !== 32'hFFFF_FFFF) $display("FAIL t6_preload: got %h required ffffffff", cnt); else pass_cnt++;
    @(posedge clk); #1;
    push_hdr(32'hE0F0_0007);
    push_line(64'h0477_0000_0000_0000, 1'b1);
    @(negedge clk);
    total_cnt++;
    if (cnt !== 32'hFFFF_FFFF) $display("FAIL t6_pre_wrap: got %h required ffffffff", cnt); else pass_cnt++;
    @(posedge clk); #1;
    @(negedge clk);
    total_cnt++;
    if (cnt !== 32'd0) $display("FAIL t6_wrap: got %h required 00000000", cnt); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single_commit();
    test_commit_drain();
    test_passthrough();
    test_commit_stall();
    test_reset_mid_msg();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion required finish before 200000 time units");
    $fatal(1);
  end

endmodule
`default_nettype wire
